// File: rtl/alu_pkg.sv
// Shared opcode encodings and handshake FSM states for the ALU execution unit.
package alu_pkg;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b010;
    localparam logic [2:0] OpDiv = 3'b011;
    localparam logic [2:0] OpAnd = 3'b100;
    localparam logic [2:0] OpOr  = 3'b101;
    localparam logic [2:0] OpXor = 3'b110;
    localparam logic [2:0] OpNot = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle for WIDTH cycles.
// o_last flags the cycle whose rising edge completes the final iteration.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    // MUL: r_acc = product, r_aux = shifted multiplicand, r_bop = shifted multiplier.
    // DIV: r_acc = dividend shifting out / quotient shifting in, r_aux = remainder, r_bop = divisor.
    logic             r_busy;
    logic             r_is_div;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_aux;
    logic [WIDTH-1:0] r_bop;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    assign w_shift  = {r_aux, r_acc[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_bop};
    assign w_fits   = (w_shift >= {1'b0, r_bop});
    assign o_last   = r_busy && (r_cnt == CntW'(WIDTH - 1));
    assign o_result = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_aux    <= '0;
            r_bop    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_is_div <= i_is_div;
            r_cnt    <= '0;
            r_acc    <= i_is_div ? i_a : '0;
            r_aux    <= i_is_div ? '0 : i_a;
            r_bop    <= i_b;
        end else if (r_busy) begin
            r_cnt <= r_cnt + CntW'(1);
            if (o_last) begin
                r_busy <= 1'b0;
            end
            if (r_is_div) begin
                r_aux <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_acc <= {r_acc[WIDTH-2:0], w_fits};
            end else begin
                if (r_bop[0]) begin
                    r_acc <= r_acc + r_aux;
                end
                r_aux <= {r_aux[WIDTH-2:0], 1'b0};
                r_bop <= {1'b0, r_bop[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: valid/ready handshake FSM, single-cycle ops, and an iterative
// MUL/DIV engine. One operation in flight at a time.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero
);

    alu_state_e       r_state;
    alu_state_e       w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_dbz;
    logic             r_use_iter;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div_iter;
    logic             w_start;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_dbz;
    logic             w_iter_last;
    logic [WIDTH-1:0] w_iter_res;

    assign w_accept      = in_valid && (r_state == StIdle);
    assign w_is_mul      = (alu_op == OpMul);
    assign w_is_div_iter = (alu_op == OpDiv) && (op_b != '0);
    assign w_start       = w_accept && (w_is_mul || w_is_div_iter);

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_is_div(w_is_div_iter),
        .i_a     (op_a),
        .i_b     (op_b),
        .o_last  (w_iter_last),
        .o_result(w_iter_res)
    );

    always_comb begin
        w_alu_res = '0;
        w_dbz     = 1'b0;
        case (alu_op)
            OpAdd: w_alu_res = op_a + op_b;
            OpSub: w_alu_res = op_a - op_b;
            OpAnd: w_alu_res = op_a & op_b;
            OpOr:  w_alu_res = op_a | op_b;
            OpXor: w_alu_res = op_a ^ op_b;
            OpNot: w_alu_res = ~op_a;
            OpDiv: begin
                w_alu_res = '1;
                w_dbz     = (op_b == '0);
            end
            default: w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_is_mul)           w_state_next = StMul;
                    else if (w_is_div_iter) w_state_next = StDiv;
                    else                    w_state_next = StDone;
                end
            end
            StMul, StDiv: if (w_iter_last) w_state_next = StDone;
            StDone:       if (out_ready)   w_state_next = StIdle;
            default:      w_state_next = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
    end

    // Registers only load on acceptance, so outputs hold while DONE waits for out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_dbz      <= 1'b0;
            r_use_iter <= 1'b0;
        end else if (w_accept) begin
            r_result   <= w_alu_res;
            r_dbz      <= w_dbz;
            r_use_iter <= w_start;
        end
    end

    assign result      = r_use_iter ? w_iter_res : r_result;
    assign zero        = out_valid && (result == '0);
    assign div_by_zero = r_dbz;

endmodule
